// File: rtl/jt10_adpcmb_enc_if.sv
// -----------------------------------------------------------------------------
// jt10_adpcmb_enc_if
// Stream interface for the ADPCM-B (delta-T) encoder.
//   in_valid / in_ready / in_pcm    : PCM sample input handshake
//   out_valid / out_ready / out_data: encoded nibble/byte output handshake
//   pcm_rec                         : reconstructed sample (decoder-identical)
// Modports:
//   master : the side that feeds samples and consumes encoded data
//   slave  : the encoder itself
// -----------------------------------------------------------------------------
interface jt10_adpcmb_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pcm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] pcm_rec;

  modport master (
    output in_valid, in_pcm, out_ready,
    input  in_ready, out_valid, out_data, pcm_rec
  );

  modport slave (
    input  in_valid, in_pcm, out_ready,
    output in_ready, out_valid, out_data, pcm_rec
  );
endinterface

// File: rtl/jt10_adpcmb_enc.sv
// -----------------------------------------------------------------------------
// jt10_adpcmb_enc
// ADPCM-B (delta-T) encoder. Turns signed 16-bit PCM samples into 4-bit
// ADPCM-B nibbles while keeping a local reconstruction (predictor x, adaptive
// step) that uses the decoder's arithmetic, so a decoder fed the produced
// nibble stream tracks pcm_rec bit-exactly.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   cen  : clock enable, all state advances only when high
//   clr  : clear request, held pending until the next cen
//   bus  : jt10_adpcmb_enc_if.slave (sample in, encoded out, pcm_rec)
//
// Parameters:
//   STEP_MIN : lower clamp and reset value of the adaptive step
//   STEP_MAX : upper clamp of the adaptive step
//
// Build option:
//   JT10_ADPCMB_ENC_PACK_EN : when defined, two consecutive nibbles are packed
//   into one byte (first nibble in out_data[7:4]); otherwise each sample emits
//   out_data = {4'b0, nibble}.
//
// Sample flow: IDLE -> DIFF -> Q2 -> Q1 -> Q0 -> UPD -> OUT (one step per cen).
// -----------------------------------------------------------------------------
module jt10_adpcmb_enc #(
  parameter int STEP_MIN = 127,
  parameter int STEP_MAX = 24576
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   clr,
  jt10_adpcmb_enc_if.slave       bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DIFF = 3'd1;
  localparam logic [2:0] Q2   = 3'd2;
  localparam logic [2:0] Q1   = 3'd3;
  localparam logic [2:0] Q0   = 3'd4;
  localparam logic [2:0] UPD  = 3'd5;
  localparam logic [2:0] OUT  = 3'd6;

  logic [2:0]  state_reg;
  logic [15:0] pcm_reg;       // captured input sample
  logic [15:0] x_reg;         // predictor (signed)
  logic [15:0] step_reg;      // adaptive step (unsigned)
  logic        sign_reg;      // sign of the current difference
  logic [18:0] t_reg;         // running remainder of 4*|diff|
  logic [2:0]  d_reg;         // quantised magnitude
  logic [7:0]  out_data_reg;
  logic [15:0] pcm_rec_reg;
  logic        clr_pend_reg;
`ifdef JT10_ADPCMB_ENC_PACK_EN
  logic        half_reg;      // a first nibble is being held
  logic [3:0]  hi_reg;        // held first nibble
`endif

  // combinational datapath
  logic [16:0] diff;
  logic [16:0] mag;
  logic [18:0] cmp_val;
  logic        q_ge;
  logic [19:0] mul;
  logic [16:0] delta;
  logic [16:0] x_ext;
  logic [16:0] xn;
  logic [15:0] x_new;
  logic [7:0]  mult;
  logic [23:0] prod;
  logic [23:0] prod_sh;
  logic [15:0] step_new;

  always_comb begin
    diff = {pcm_reg[15], pcm_reg} - {x_reg[15], x_reg};
    mag  = diff[16] ? (17'd0 - diff) : diff;

    // Restoring division of 4*mag by step, one bit per state.
    case (state_reg)
      Q2:      cmp_val = {1'b0, step_reg, 2'b00};
      Q1:      cmp_val = {2'b00, step_reg, 1'b0};
      default: cmp_val = {3'b000, step_reg};
    endcase
    q_ge = (t_reg >= cmp_val);

    mul   = 20'({d_reg, 1'b1}) * 20'(step_reg);
    delta = 17'(mul >> 3);
    x_ext = {x_reg[15], x_reg};
    xn    = sign_reg ? (x_ext - delta) : (x_ext + delta);
    // The 17-bit sum cannot wrap past bit 16 for legal step values, so a
    // mismatch of the top two bits always means a 16-bit overflow.
    if (xn[16] ^ xn[15])
      x_new = sign_reg ? 16'h8000 : 16'h7fff;
    else
      x_new = xn[15:0];

    case (d_reg)
      3'd4:    mult = 8'd77;
      3'd5:    mult = 8'd102;
      3'd6:    mult = 8'd128;
      3'd7:    mult = 8'd153;
      default: mult = 8'd57;
    endcase
    prod    = 24'(step_reg) * 24'(mult);
    prod_sh = prod >> 6;
    if (prod_sh < 24'(STEP_MIN))
      step_new = 16'(STEP_MIN);
    else if (prod_sh > 24'(STEP_MAX))
      step_new = 16'(STEP_MAX);
    else
      step_new = prod_sh[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pcm_reg      <= 16'd0;
      x_reg        <= 16'd0;
      step_reg     <= 16'(STEP_MIN);
      sign_reg     <= 1'b0;
      t_reg        <= 19'd0;
      d_reg        <= 3'd0;
      out_data_reg <= 8'd0;
      pcm_rec_reg  <= 16'd0;
      clr_pend_reg <= 1'b0;
`ifdef JT10_ADPCMB_ENC_PACK_EN
      half_reg     <= 1'b0;
      hi_reg       <= 4'd0;
`endif
    end else if (!cen) begin
      // clr arriving while disabled is remembered for the next cen
      if (clr)
        clr_pend_reg <= 1'b1;
    end else begin
      clr_pend_reg <= 1'b0;
      if (clr || clr_pend_reg) begin
        state_reg   <= IDLE;
        x_reg       <= 16'd0;
        step_reg    <= 16'(STEP_MIN);
        pcm_rec_reg <= 16'd0;
`ifdef JT10_ADPCMB_ENC_PACK_EN
        half_reg    <= 1'b0;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.in_valid) begin
              pcm_reg   <= bus.in_pcm;
              state_reg <= DIFF;
            end
          end
          DIFF: begin
            sign_reg  <= diff[16];
            t_reg     <= {mag, 2'b00};
            state_reg <= Q2;
          end
          Q2: begin
            d_reg[2] <= q_ge;
            if (q_ge)
              t_reg <= t_reg - cmp_val;
            state_reg <= Q1;
          end
          Q1: begin
            d_reg[1] <= q_ge;
            if (q_ge)
              t_reg <= t_reg - cmp_val;
            state_reg <= Q0;
          end
          Q0: begin
            d_reg[0]  <= q_ge;
            state_reg <= UPD;
          end
          UPD: begin
            x_reg       <= x_new;
            step_reg    <= step_new;
            pcm_rec_reg <= x_new;
`ifdef JT10_ADPCMB_ENC_PACK_EN
            if (half_reg) begin
              out_data_reg <= {hi_reg, sign_reg, d_reg};
              half_reg     <= 1'b0;
              state_reg    <= OUT;
            end else begin
              hi_reg    <= {sign_reg, d_reg};
              half_reg  <= 1'b1;
              state_reg <= IDLE;
            end
`else
            out_data_reg <= {4'b0000, sign_reg, d_reg};
            state_reg    <= OUT;
`endif
          end
          OUT: begin
            if (bus.out_ready)
              state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == OUT);
  assign bus.out_data  = out_data_reg;
  assign bus.pcm_rec   = pcm_rec_reg;

endmodule

// File: tb/tb_jt10_adpcmb_enc.sv
// -----------------------------------------------------------------------------
// tb_jt10_adpcmb_enc
// Directed bench for jt10_adpcmb_enc: table of hand-computed vectors, full
// scale saturation runs, backpressure, clr handling and a decoder loopback.
// -----------------------------------------------------------------------------
module tb_jt10_adpcmb_enc;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic clr;

  jt10_adpcmb_enc_if bus ();

  jt10_adpcmb_enc dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // decoder reference state for loopback
  int dec_x;
  int dec_step;

  typedef struct {
    bit          do_rst;
    logic [15:0] pcm;
    logic [3:0]  nib;
    logic [15:0] rec;
    logic [15:0] step;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pcm    = 16'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Send one sample; returns the output byte if one was produced and the
  // reconstructed sample after its update step.
  task automatic encode(input logic [15:0] pcm, output logic [7:0] data,
                        output bit emitted, output logic [15:0] rec);
    int n;
    n = 0;
    bus.in_pcm   = pcm;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100)
      check("in_ready_timeout", 32'd0, 32'd1);
    tick();                 // handshake edge
    bus.in_valid = 1'b0;
    repeat (5) tick();      // DIFF, Q2, Q1, Q0, UPD
    emitted = (bus.out_valid === 1'b1);
    data    = bus.out_data;
    rec     = bus.pcm_rec;
    if (emitted) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic dec_nib(input logic [3:0] nib);
    int d;
    int delta;
    int mult;
    d     = int'(nib[2:0]);
    delta = ((2 * d + 1) * dec_step) / 8;
    if (nib[3]) dec_x = dec_x - delta;
    else        dec_x = dec_x + delta;
    if (dec_x > 32767)  dec_x = 32767;
    if (dec_x < -32768) dec_x = -32768;
    case (d)
      4:       mult = 77;
      5:       mult = 102;
      6:       mult = 128;
      7:       mult = 153;
      default: mult = 57;
    endcase
    dec_step = (dec_step * mult) / 64;
    if (dec_step < 127)   dec_step = 127;
    if (dec_step > 24576) dec_step = 24576;
  endtask

  initial begin
    vec_t        vecs [10];
    logic [7:0]  data;
    logic [7:0]  data0;
    logic [15:0] rec;
    logic [15:0] rec1;
    logic [15:0] prev;
    logic [15:0] smp;
    logic [3:0]  pend_nib;
    bit          pend;
    bit          emitted;
    int          bad;
    int          n;
    int          max_step;
    int          min_rec;

    vecs[0] = '{1'b1, 16'd0,       4'h0, 16'd15,      16'd127};
    vecs[1] = '{1'b1, -16'sd1000,  4'hF, -16'sd238,   16'd303};
    vecs[2] = '{1'b1, 16'd1000,    4'h7, 16'd238,     16'd303};
    vecs[3] = '{1'b0, 16'd1000,    4'h7, 16'd806,     16'd724};
    vecs[4] = '{1'b0, 16'd800,     4'h8, 16'd716,     16'd644};
    vecs[5] = '{1'b0, 16'd1416,    4'h4, 16'd1440,    16'd774};
    vecs[6] = '{1'b0, 16'd440,     4'hD, 16'd376,     16'd1233};
    vecs[7] = '{1'b0, 16'd2376,    4'h6, 16'd2379,    16'd2466};
    vecs[8] = '{1'b0, 16'd879,     4'hA, 16'd838,     16'd2196};
    vecs[9] = '{1'b0, 16'd838,     4'h0, 16'd1112,    16'd1955};

    // ---- reset state ----
    do_reset();
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_pcm_rec",   32'(bus.pcm_rec),   32'd0);
    check("rst_x",         32'(dut.x_reg),     32'd0);
    check("rst_step",      32'(dut.step_reg),  32'd127);

    // ---- cen=0 freezes the handshake ----
    cen = 1'b0;
    bus.in_pcm   = 16'd1000;
    bus.in_valid = 1'b1;
    repeat (5) tick();
    check("cen0_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    cen = 1'b1;
    tick();
    check("cen1_no_capture", 32'(bus.in_ready), 32'd1);

    // ---- directed vector table ----
    pend = 1'b0;
    pend_nib = 4'h0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) begin
        do_reset();
        pend = 1'b0;
      end
      encode(vecs[i].pcm, data, emitted, rec);
      $display("vec %0d: pcm=%0d emitted=%0d data=%02h rec=%0d step=%0d",
               i, $signed(vecs[i].pcm), emitted, data, $signed(rec), dut.step_reg);
      check("vec_rec",  32'(rec),          32'(vecs[i].rec));
      check("vec_step", 32'(dut.step_reg), 32'(vecs[i].step));
`ifdef JT10_ADPCMB_ENC_PACK_EN
      check("vec_emit", 32'(emitted), 32'(pend));
      if (pend) check("vec_byte", 32'(data), 32'({pend_nib, vecs[i].nib}));
      pend_nib = vecs[i].nib;
      pend = !pend;
`else
      check("vec_emit", 32'(emitted), 32'd1);
      check("vec_data", 32'(data), 32'({4'h0, vecs[i].nib}));
`endif
    end

    // ---- hold full-scale positive: saturate at 32767, never wrap ----
    do_reset();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      encode(16'h7fff, data, emitted, rec);
      if (rec[15] !== 1'b0) bad++;
    end
    $display("hold +32767: rec=%0d step=%0d", $signed(rec), dut.step_reg);
    check("pos_hold_no_wrap", 32'(bad), 32'd0);
    check("pos_hold_final",   32'(rec), 32'h7fff);

    // ---- hold full-scale negative: reaches -32768, never wraps ----
    do_reset();
    bad = 0;
    min_rec = 0;
    for (int i = 0; i < 200; i++) begin
      encode(16'h8000, data, emitted, rec);
      if (rec[15] !== 1'b1) bad++;
      if (int'($signed(rec)) < min_rec) min_rec = int'($signed(rec));
    end
    $display("hold -32768: min_rec=%0d step=%0d", min_rec, dut.step_reg);
    check("neg_hold_no_wrap", 32'(bad), 32'd0);
    check("neg_hold_floor",   32'(min_rec), 32'(-32768));

    // ---- alternating full scale: step clamps at exactly STEP_MAX ----
    do_reset();
    bad = 0;
    max_step = 0;
    prev = 16'd0;
    for (int i = 0; i < 200; i++) begin
      smp = (i % 2 == 0) ? 16'h7fff : 16'h8000;
      encode(smp, data, emitted, rec);
      if (i % 2 == 0 && $signed(rec) < $signed(prev)) bad++;
      if (i % 2 == 1 && $signed(rec) > $signed(prev)) bad++;
      if (int'(dut.step_reg) > max_step) max_step = int'(dut.step_reg);
      prev = rec;
    end
    $display("alternate: max_step=%0d", max_step);
    check("alt_direction", 32'(bad), 32'd0);
    check("alt_step_max",  32'(max_step), 32'd24576);

    // ---- backpressure ----
    do_reset();
    bus.in_pcm   = 16'd1000;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    data0 = bus.out_data;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== data0) bad++;
    end
    $display("backpressure: data=%02h bad=%0d", data0, bad);
    check("bp_stable", 32'(bad), 32'd0);
`ifdef JT10_ADPCMB_ENC_PACK_EN
    check("bp_data", 32'(data0), 32'h77);
`else
    check("bp_data", 32'(data0), 32'h07);
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready),  32'd1);

    // ---- clr while cen=0 stays pending, serviced at next cen ----
    do_reset();
    encode(16'd1000, data, emitted, rec);
    cen = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr_pending_x",    32'(dut.x_reg),    32'd238);
    check("clr_pending_step", 32'(dut.step_reg), 32'd303);
    cen = 1'b1;
    tick();
    check("clr_serviced_x",    32'(dut.x_reg),    32'd0);
    check("clr_serviced_step", 32'(dut.step_reg), 32'd127);

    // ---- clr during Q1 aborts the sample ----
    do_reset();
    encode(16'd1000, data, emitted, rec);
    bus.in_pcm   = 16'd1000;
    bus.in_valid = 1'b1;
    tick();                 // handshake -> DIFF
    bus.in_valid = 1'b0;
    tick();                 // Q2
    tick();                 // Q1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_q1_x",        32'(dut.x_reg),     32'd0);
    check("clr_q1_step",     32'(dut.step_reg),  32'd127);
    check("clr_q1_in_ready", 32'(bus.in_ready),  32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      tick();
    end
    check("clr_q1_no_output", 32'(bad), 32'd0);

    // ---- loopback through a reference decoder ----
    do_reset();
    dec_x    = 0;
    dec_step = 127;
    rec1     = 16'd0;
    for (int i = 0; i < 128; i++) begin
      if (i < 64)
        smp = 16'($rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 16.0)));
      else
        smp = 16'($urandom);
      encode(smp, data, emitted, rec);
      $display("loop %0d: pcm=%0d emitted=%0d data=%02h rec=%0d",
               i, $signed(smp), emitted, data, $signed(rec));
`ifdef JT10_ADPCMB_ENC_PACK_EN
      if (!emitted) begin
        rec1 = rec;
      end else begin
        dec_nib(data[7:4]);
        check("loop_hi", 32'($signed(rec1)), 32'(dec_x));
        dec_nib(data[3:0]);
        check("loop_lo", 32'($signed(rec)), 32'(dec_x));
      end
`else
      check("loop_emit", 32'(emitted), 32'd1);
      dec_nib(data[3:0]);
      check("loop_rec", 32'($signed(rec)), 32'(dec_x));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
